exe_hazard_fwd_unit: RTL and testbench

- Consumer-side companion to the ID/EX pipeline register: reads the ID/EX outputs and the decode-stage source fields every cycle.
- Tracks in-flight destination registers for EX/MEM and MEM/WB in internal shadow pipes.
- Produces EX operand forwarding selects, load-use stall control and branch flush control back into the IF/ID and ID/EX registers.
- Sits between the decode stage, the ID/EX register and the EX-stage operand muxes.

---
 rtl/exe_hazard_fwd_unit_if.sv | 32 +++
 rtl/exe_hazard_fwd_unit.sv | 129 ++++++++++++
 tb/tb_exe_hazard_fwd_unit.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/exe_hazard_fwd_unit_if.sv
// Bundle between the decode stage / ID-EX register and the hazard and forwarding unit.
// The pipeline side uses master; the hazard unit uses slave.
interface exe_hazard_fwd_unit_if #(
    parameter int REG_AW = 5
);
    logic [REG_AW-1:0] IdRs;
    logic [REG_AW-1:0] IdRt;
    logic [3:0]        ExWb;
    logic [1:0]        ExM;
    logic [4:0]        ExEx;
    logic [REG_AW-1:0] ExRs;
    logic [REG_AW-1:0] ExRt;
    logic [REG_AW-1:0] ExRd;
    logic              BrTaken;
    logic [1:0]        ForwardA;
    logic [1:0]        ForwardB;
    logic              PcWrite;
    logic              IfIdWrite;
    logic              IfIdFlush;
    logic              IdExFlush;
    logic [15:0]       StallCnt;

    modport master (
        output IdRs, IdRt, ExWb, ExM, ExEx, ExRs, ExRt, ExRd, BrTaken,
        input  ForwardA, ForwardB, PcWrite, IfIdWrite, IfIdFlush, IdExFlush, StallCnt
    );

    modport slave (
        input  IdRs, IdRt, ExWb, ExM, ExEx, ExRs, ExRt, ExRd, BrTaken,
        output ForwardA, ForwardB, PcWrite, IfIdWrite, IfIdFlush, IdExFlush, StallCnt
    );
endinterface

// File: rtl/exe_hazard_fwd_unit.sv
// EX operand forwarding, load-use stall and branch flush control.
// Optional stall-cycle statistic counter is built when HAZ_STALL_STATS_EN is defined.
module exe_hazard_fwd_unit #(
    parameter int LOAD_LAT = 1,
    parameter int REG_AW   = 5
) (
    input logic                  clk,
    input logic                  rst_n,
    exe_hazard_fwd_unit_if.slave bus
);
    typedef enum logic {RUN, STALL} state_e;

    state_e            state_q, state_d;
    logic [2:0]        bubCnt_q, bubCnt_d;
    logic [REG_AW-1:0] exDst;
    logic [REG_AW-1:0] memDst_q, wbDst_q;
    logic              memRegWr_q, wbRegWr_q;
    logic              hz;
    logic              unusedCtrl;

    assign unusedCtrl = ^{bus.ExWb[3:1], bus.ExM[0], bus.ExEx[4:1]};

    assign exDst = bus.ExEx[0] ? bus.ExRd : bus.ExRt;
    assign hz    = bus.ExM[1] && (exDst != '0) && ((exDst == bus.IdRs) || (exDst == bus.IdRt));

    function automatic logic [1:0] fwdSel(
        input logic [REG_AW-1:0] src,
        input logic              memWr,
        input logic [REG_AW-1:0] memDst,
        input logic              wbWr,
        input logic [REG_AW-1:0] wbDst
    );
        if (memWr && (memDst != '0) && (memDst == src)) return 2'b10;
        if (wbWr && (wbDst != '0) && (wbDst == src)) return 2'b01;
        return 2'b00;
    endfunction

    assign bus.ForwardA = fwdSel(bus.ExRs, memRegWr_q, memDst_q, wbRegWr_q, wbDst_q);
    assign bus.ForwardB = fwdSel(bus.ExRt, memRegWr_q, memDst_q, wbRegWr_q, wbDst_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            memDst_q   <= '0;
            memRegWr_q <= 1'b0;
            wbDst_q    <= '0;
            wbRegWr_q  <= 1'b0;
        end else begin
            memDst_q   <= exDst;
            memRegWr_q <= bus.ExWb[0];
            wbDst_q    <= memDst_q;
            wbRegWr_q  <= memRegWr_q;
        end
    end

    // The detecting cycle is already bubble 1, so bubCnt holds the bubbles still owed after it.
    always_comb begin
        state_d  = state_q;
        bubCnt_d = bubCnt_q;
        if (bus.BrTaken) begin
            state_d  = RUN;
            bubCnt_d = '0;
        end else begin
            case (state_q)
                RUN: begin
                    if (hz && (LOAD_LAT > 1)) begin
                        state_d  = STALL;
                        bubCnt_d = 3'(LOAD_LAT - 1);
                    end
                end
                STALL: begin
                    if (bubCnt_q <= 3'd1) begin
                        state_d  = RUN;
                        bubCnt_d = '0;
                    end else begin
                        bubCnt_d = bubCnt_q - 3'd1;
                    end
                end
                default: begin
                    state_d  = RUN;
                    bubCnt_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= RUN;
            bubCnt_q <= '0;
        end else begin
            state_q  <= state_d;
            bubCnt_q <= bubCnt_d;
        end
    end

    // Reset forces the free-running defaults even while hazard inputs are active.
    always_comb begin
        bus.PcWrite   = 1'b1;
        bus.IfIdWrite = 1'b1;
        bus.IfIdFlush = 1'b0;
        bus.IdExFlush = 1'b0;
        if (rst_n) begin
            if (bus.BrTaken) begin
                bus.IfIdFlush = 1'b1;
                bus.IdExFlush = 1'b1;
            end else if ((state_q == STALL) || hz) begin
                bus.PcWrite   = 1'b0;
                bus.IfIdWrite = 1'b0;
                bus.IdExFlush = 1'b1;
            end
        end
    end

`ifdef HAZ_STALL_STATS_EN
    logic [15:0] stallCnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stallCnt_q <= '0;
        end else if (!bus.PcWrite && (stallCnt_q != 16'hFFFF)) begin
            stallCnt_q <= stallCnt_q + 16'd1;
        end
    end

    assign bus.StallCnt = stallCnt_q;
`else
    assign bus.StallCnt = 16'h0000;
`endif
endmodule

// File: tb/tb_exe_hazard_fwd_unit.sv
// Directed bench for exe_hazard_fwd_unit: three instances (LOAD_LAT 1..3) share one stimulus.
// Output word layout: {ForwardA, ForwardB, PcWrite, IfIdWrite, IfIdFlush, IdExFlush}.
module tb_exe_hazard_fwd_unit;
    logic       clk = 1'b0;
    logic       rstN = 1'b0;
    logic [4:0] idRs, idRt, exEx, exRs, exRt, exRd;
    logic [3:0] exWb;
    logic [1:0] exM;
    logic       brTaken;

    logic [7:0]  obs  [3];
    logic [15:0] stat [3];

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : gLat
        exe_hazard_fwd_unit_if #(.REG_AW(5)) bus ();
        assign bus.IdRs    = idRs;
        assign bus.IdRt    = idRt;
        assign bus.ExWb    = exWb;
        assign bus.ExM     = exM;
        assign bus.ExEx    = exEx;
        assign bus.ExRs    = exRs;
        assign bus.ExRt    = exRt;
        assign bus.ExRd    = exRd;
        assign bus.BrTaken = brTaken;
        assign obs[g]  = {bus.ForwardA, bus.ForwardB, bus.PcWrite, bus.IfIdWrite,
                          bus.IfIdFlush, bus.IdExFlush};
        assign stat[g] = bus.StallCnt;

        exe_hazard_fwd_unit #(.LOAD_LAT(g + 1), .REG_AW(5)) dut (
            .clk   (clk),
            .rst_n (rstN),
            .bus   (bus.slave)
        );
    end

    typedef struct {
        logic [4:0] idRs, idRt;
        logic [3:0] exWb;
        logic [1:0] exM;
        logic [4:0] exEx, exRs, exRt, exRd;
        logic       brTaken;
        logic [7:0] expOut;
    } vec_t;

    localparam int NV = 16;
    vec_t vec [NV];

    function automatic vec_t mk(input int a, input int b, input int wb, input int m, input int ex,
                                input int rs, input int rt, input int rd, input int br,
                                input logic [7:0] e);
        vec_t v;
        v.idRs = 5'(a);  v.idRt = 5'(b);  v.exWb = 4'(wb); v.exM = 2'(m);
        v.exEx = 5'(ex); v.exRs = 5'(rs); v.exRt = 5'(rt); v.exRd = 5'(rd);
        v.brTaken = 1'(br); v.expOut = e;
        return v;
    endfunction

    task automatic zeroInputs();
        idRs = '0; idRt = '0; exWb = '0; exM = '0; exEx = '0;
        exRs = '0; exRt = '0; exRd = '0; brTaken = 1'b0;
    endtask

    task automatic applyStimulus(input vec_t v);
        idRs = v.idRs; idRt = v.idRt; exWb = v.exWb; exM = v.exM; exEx = v.exEx;
        exRs = v.exRs; exRt = v.exRt; exRd = v.exRd; brTaken = v.brTaken;
    endtask

    task automatic loadUse();
        zeroInputs();
        idRs = 5'd3; exM = 2'b10; exEx = 5'd0; exRt = 5'd3; exWb = 4'd1;
    endtask

    task automatic checkOutput(input string name, input int idx, input logic [7:0] expv);
        compared++;
        if (obs[idx] !== expv) begin
            mismatched++;
            $display("[TB] FAIL %s lat%0d: got %b expected %b", name, idx + 1, obs[idx], expv);
        end
    endtask

    task automatic checkValue(input string name, input int act, input int expv);
        compared++;
        if (act != expv) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        zeroInputs();
        rstN = 1'b0;
        @(negedge clk);
        rstN = 1'b1;
        nextCycle();
    endtask

    initial begin
        int cnt [3];
        int expStat [3];

        vec[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 8'b0000_1100);
        vec[1]  = mk(0, 0, 1, 0, 1, 1, 2, 5, 0, 8'b0000_1100);
        vec[2]  = mk(0, 0, 1, 0, 1, 5, 6, 8, 0, 8'b1000_1100);
        vec[3]  = mk(0, 0, 0, 0, 0, 9, 5, 0, 0, 8'b0001_1100);
        vec[4]  = mk(0, 0, 1, 0, 1, 8, 5, 7, 0, 8'b0100_1100);
        vec[5]  = mk(0, 0, 1, 0, 1, 3, 4, 7, 0, 8'b0000_1100);
        vec[6]  = mk(0, 0, 1, 0, 1, 7, 7, 0, 0, 8'b1010_1100);
        vec[7]  = mk(0, 0, 1, 0, 1, 0, 7, 0, 0, 8'b0001_1100);
        vec[8]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 8'b0000_1100);
        vec[9]  = mk(3, 0, 1, 2, 0, 0, 3, 0, 0, 8'b0000_0001);
        vec[10] = mk(3, 0, 0, 0, 0, 0, 0, 0, 0, 8'b0000_1100);
        vec[11] = mk(0, 0, 0, 0, 0, 3, 0, 0, 0, 8'b0100_1100);
        vec[12] = mk(1, 4, 1, 2, 1, 0, 0, 4, 0, 8'b0000_0001);
        vec[13] = mk(0, 0, 1, 2, 0, 0, 0, 0, 0, 8'b0000_1100);
        vec[14] = mk(0, 6, 0, 2, 0, 0, 6, 0, 1, 8'b0000_1111);
        vec[15] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 8'b0000_1100);

        // Outputs held at defaults while reset is low, even with hazard/branch inputs present.
        loadUse();
        #3;
        for (int k = 0; k < 3; k++) checkOutput("resetHz", k, 8'b0000_1100);
        brTaken = 1'b1;
        #3;
        for (int k = 0; k < 3; k++) checkOutput("resetBr", k, 8'b0000_1100);
        for (int k = 0; k < 3; k++) checkValue($sformatf("resetStat%0d", k), int'(stat[k]), 0);
        doReset();

        for (int i = 0; i < NV; i++) begin
            applyStimulus(vec[i]);
            #2;
            checkOutput($sformatf("vec%0d", i), 0, vec[i].expOut);
            nextCycle();
        end

        // Bubble count per LOAD_LAT for a single load-use event.
        doReset();
        for (int k = 0; k < 3; k++) cnt[k] = 0;
        for (int c = 0; c < 7; c++) begin
            if (c == 0) loadUse();
            else begin
                zeroInputs();
                idRs = 5'd3;
            end
            #2;
            if (c == 2) checkOutput("lat3Bubble3", 2, 8'b0000_0001);
            for (int k = 0; k < 3; k++) if (obs[k][3] == 1'b0) cnt[k]++;
            nextCycle();
        end
        for (int k = 0; k < 3; k++) checkValue($sformatf("bubbles%0d", k + 1), cnt[k], k + 1);

        // Branch in the second bubble aborts the stall; branch with hazard enters no stall.
        doReset();
        loadUse();
        #2;
        checkOutput("brDetect", 2, 8'b0000_0001);
        nextCycle();
        zeroInputs();
        idRs = 5'd3;
        brTaken = 1'b1;
        #2;
        checkOutput("brInStall", 2, 8'b0000_1111);
        nextCycle();
        zeroInputs();
        #2;
        checkOutput("brAfter", 2, 8'b0000_1100);
        nextCycle();
        loadUse();
        brTaken = 1'b1;
        #2;
        checkOutput("hzAndBr", 2, 8'b0000_1111);
        nextCycle();
        zeroInputs();
        #2;
        checkOutput("hzAndBrNext3", 2, 8'b0000_1100);
        checkOutput("hzAndBrNext2", 1, 8'b0000_1100);
        nextCycle();

        // Reset dropped between edges in the middle of a stall.
        doReset();
        loadUse();
        nextCycle();
        zeroInputs();
        exRs = 5'd3;
        #2;
        checkOutput("preResetStall", 2, 8'b1000_0001);
        rstN = 1'b0;
        #1;
        checkOutput("midReset", 2, 8'b0000_1100);
        #2;
        rstN = 1'b1;
        zeroInputs();
        nextCycle();
        cnt[2] = 0;
        for (int c = 0; c < 4; c++) begin
            #2;
            if (obs[2][3] == 1'b0) cnt[2]++;
            nextCycle();
        end
        checkValue("residualBubbles", cnt[2], 0);

        // Stall statistic over three load-use events.
        doReset();
        for (int e = 0; e < 3; e++) begin
            loadUse();
            nextCycle();
            zeroInputs();
            repeat (4) nextCycle();
        end
`ifdef HAZ_STALL_STATS_EN
        expStat = '{3, 6, 9};
`else
        expStat = '{0, 0, 0};
`endif
        for (int k = 0; k < 3; k++)
            checkValue($sformatf("stallCnt%0d", k + 1), int'(stat[k]), expStat[k]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
